// File: rtl/kl_pipe_pkg.sv
// Shared types and default sizes for the forwarding scoreboard.
// Per-stage control bits; num/data are held in parallel arrays.
package kl_pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREG_DEF   = 8;
    localparam int DEPTH_DEF  = 6;
    localparam int NRD_DEF    = 2;

    typedef struct packed {
        logic valid;
        logic wr;
        logic ready;
    } ent_ctl_t;

endpackage

// File: rtl/fwd_lookup.sv
// Per-port priority lookup across the in-flight stages.
// The youngest matching writer decides the operand source.
module fwd_lookup
    import kl_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = 3,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SW     = $clog2(DEPTH + 1)
) (
    input  ent_ctl_t [DEPTH-1:0]         i_ent,
    input  logic [DEPTH-1:0][AW-1:0]     i_num,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
    input  logic                         i_res_valid,
    input  logic [SW-1:0]                i_res_stage,
    input  logic [DATA_W-1:0]            i_res_data,
    input  logic [AW-1:0]                i_rd_num,
    input  logic [DATA_W-1:0]            i_rd_reg_data,
    output logic [DATA_W-1:0]            o_fwd_data,
    output logic                         o_hazard
);

    logic              w_hit;
    logic              w_rdy;
    logic [DATA_W-1:0] w_dat;
    logic [SW-1:0]     w_stg;

    always_comb begin
        w_hit = 1'b0;
        w_rdy = 1'b0;
        w_dat = '0;
        w_stg = '0;
        // Scan oldest to youngest so the youngest match overwrites.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_ent[k].valid && i_ent[k].wr &&
                i_num[k] == i_rd_num) begin
                w_hit = 1'b1;
                w_rdy = i_ent[k].ready;
                w_dat = i_data[k];
                w_stg = SW'(k + 1);
            end
        end
    end

    always_comb begin
        o_fwd_data = i_rd_reg_data;
        o_hazard   = 1'b0;
        if (w_hit) begin
            if (w_rdy)
                o_fwd_data = w_dat;
            else if (i_res_valid && i_res_stage == w_stg)
                o_fwd_data = i_res_data;
            else
                o_hazard = 1'b1;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight result tracker with operand forwarding and in-order retire.
// Stage index 0 in the arrays is pipeline stage 1 (youngest).
module fwd_scoreboard
    import kl_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int AW     = $clog2(NREG),
    parameter int SW     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic                  flush,
    input  logic                  iss_valid,
    input  logic                  iss_wr,
    input  logic [AW-1:0]         iss_num,
    input  logic                  res_valid,
    input  logic [SW-1:0]         res_stage,
    input  logic [DATA_W-1:0]     res_data,
    input  logic [NRD*AW-1:0]     rd_num,
    input  logic [NRD*DATA_W-1:0] rd_reg_data,
    output logic [NRD*DATA_W-1:0] fwd_data,
    output logic [NRD-1:0]        hazard,
    output logic                  stall,
    output logic                  ret_valid,
    output logic [AW-1:0]         ret_num,
    output logic [DATA_W-1:0]     ret_data,
    output logic                  ret_err
);

    ent_ctl_t [DEPTH-1:0]         r_ent;
    logic [DEPTH-1:0][AW-1:0]     r_num;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    logic [DEPTH-1:0]             w_res_hit;
    logic [DEPTH-1:0]             w_rdy;
    logic [DEPTH-1:0][DATA_W-1:0] w_dat;

    // Each entry as it would look after this cycle's late result.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_res_hit[k] = res_valid && res_stage == SW'(k + 1) &&
                           r_ent[k].valid && r_ent[k].wr;
            w_rdy[k]     = r_ent[k].ready | w_res_hit[k];
            w_dat[k]     = w_res_hit[k] ? res_data : r_data[k];
        end
    end

    assign ret_valid = adv & ~flush &
                       r_ent[DEPTH-1].valid & r_ent[DEPTH-1].wr;
    assign ret_num   = r_num[DEPTH-1];
    assign ret_data  = w_dat[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent  <= '0;
            r_num  <= '0;
            r_data <= '0;
        end else if (flush) begin
            r_ent  <= '0;
            r_num  <= '0;
            r_data <= '0;
        end else if (adv) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_ent[k].valid <= r_ent[k-1].valid;
                r_ent[k].wr    <= r_ent[k-1].wr;
                r_ent[k].ready <= w_rdy[k-1];
                r_num[k]       <= r_num[k-1];
                r_data[k]      <= w_dat[k-1];
            end
            r_ent[0].valid <= iss_valid;
            r_ent[0].wr    <= iss_wr;
            r_ent[0].ready <= 1'b0;
            r_num[0]       <= iss_num;
            r_data[0]      <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_ent[k].ready <= w_rdy[k];
                r_data[k]      <= w_dat[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ret_err <= 1'b0;
        else if (ret_valid && !w_rdy[DEPTH-1])
            ret_err <= 1'b1;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_lookup #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .DEPTH  (DEPTH),
            .SW     (SW)
        ) u_lookup (
            .i_ent         (r_ent),
            .i_num         (r_num),
            .i_data        (r_data),
            .i_res_valid   (res_valid),
            .i_res_stage   (res_stage),
            .i_res_data    (res_data),
            .i_rd_num      (rd_num[p*AW +: AW]),
            .i_rd_reg_data (rd_reg_data[p*DATA_W +: DATA_W]),
            .o_fwd_data    (fwd_data[p*DATA_W +: DATA_W]),
            .o_hazard      (hazard[p])
        );
    end

    assign stall = |hazard;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with a retire scoreboard queue.
module tb_fwd_scoreboard;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          adv, flush;
    logic          iss_valid, iss_wr;
    logic [AW-1:0] iss_num;
    logic          res_valid;
    logic [SW-1:0] res_stage;
    logic [DW-1:0] res_data;
    logic [2*AW-1:0] rd_num;
    logic [2*DW-1:0] rd_reg_data;
    logic [2*DW-1:0] fwd_data;
    logic [1:0]      hazard;
    logic            stall;
    logic            ret_valid;
    logic [AW-1:0]   ret_num;
    logic [DW-1:0]   ret_data;
    logic            ret_err;

    int checks   = 0;
    int failures = 0;
    int ret_cnt  = 0;

    typedef struct {
        logic [AW-1:0] num;
        logic [DW-1:0] data;
    } ret_t;
    ret_t sb[$];

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv         (adv),
        .flush       (flush),
        .iss_valid   (iss_valid),
        .iss_wr      (iss_wr),
        .iss_num     (iss_num),
        .res_valid   (res_valid),
        .res_stage   (res_stage),
        .res_data    (res_data),
        .rd_num      (rd_num),
        .rd_reg_data (rd_reg_data),
        .fwd_data    (fwd_data),
        .hazard      (hazard),
        .stall       (stall),
        .ret_valid   (ret_valid),
        .ret_num     (ret_num),
        .ret_data    (ret_data),
        .ret_err     (ret_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] n);
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_num   = n;
        adv       = 1'b1;
        tick();
        iss_valid = 1'b0;
        adv       = 1'b0;
    endtask

    task automatic result(input logic [SW-1:0] s, input logic [DW-1:0] d);
        res_valid = 1'b1;
        res_stage = s;
        res_data  = d;
    endtask

    // Retire monitor: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (ret_valid) begin
            ret_cnt++;
            if (sb.size() == 0) begin
                chk("ret_unexpected", 32'(ret_num), 32'hFFFF_FFFF);
            end else begin
                ret_t e;
                e = sb.pop_front();
                chk("ret_num", 32'(ret_num), 32'(e.num));
                chk("ret_data", 32'(ret_data), 32'(e.data));
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        adv         = 1'b0;
        flush       = 1'b0;
        iss_valid   = 1'b0;
        iss_wr      = 1'b0;
        iss_num     = '0;
        res_valid   = 1'b0;
        res_stage   = '0;
        res_data    = '0;
        rd_num      = {3'd3, 3'd3};
        rd_reg_data = {16'hBEEF, 16'hCAFE};
        #3;
        chk("rst_fwd", fwd_data, {16'hBEEF, 16'hCAFE});
        chk("rst_haz", 32'(hazard), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_retv", 32'(ret_valid), 0);
        chk("rst_err", 32'(ret_err), 0);
        #9 rst_n = 1'b1;
        tick();
        chk("idle_fwd", fwd_data, {16'hBEEF, 16'hCAFE});

        // Result then read
        issue(3'd3);
        chk("r3_haz_pre", 32'(hazard), 32'b11);
        result(3'd1, 16'h1234);
        #1 chk("r3_bypass", fwd_data[15:0], 16'h1234);
        tick();
        res_valid = 1'b0;
        #1;
        chk("r3_fwd", fwd_data[15:0], 16'h1234);
        chk("r3_haz", 32'(hazard), 0);

        // Unresolved hazard and same-cycle bypass
        issue(3'd5);
        rd_num = {3'd5, 3'd3};
        #1;
        chk("r5_haz", 32'(hazard), 32'b10);
        chk("r5_stall", 32'(stall), 1);
        chk("r5_regdata", fwd_data[31:16], 16'hBEEF);
        chk("r3_old", fwd_data[15:0], 16'h1234);
        result(3'd1, 16'h00AA);
        #1;
        chk("r5_bypass", fwd_data[31:16], 16'h00AA);
        chk("r5_nostall", 32'(stall), 0);
        res_valid = 1'b0;
        #1;

        // Two writers of r2: the younger one wins
        issue(3'd2);
        result(3'd1, 16'h1111);
        tick();
        res_valid = 1'b0;
        issue(3'd2);
        rd_num = {3'd7, 3'd2};
        #1;
        chk("r2_young_haz", 32'(hazard), 32'b01);
        chk("r7_nomatch", fwd_data[31:16], 16'hBEEF);
        result(3'd1, 16'h2222);
        tick();
        res_valid = 1'b0;
        #1;
        chk("r2_young", fwd_data[15:0], 16'h2222);
        chk("r2_haz", 32'(hazard), 0);
        rd_num = {3'd5, 3'd3};
        #1;
        chk("r5_stale_haz", 32'(hazard), 32'b10);
        chk("r3_deep", fwd_data[15:0], 16'h1234);

        // Flush with adv and a same-cycle issue
        flush     = 1'b1;
        adv       = 1'b1;
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_num   = 3'd5;
        result(3'd1, 16'h7777);
        #1 chk("flush_retv", 32'(ret_valid), 0);
        tick();
        flush     = 1'b0;
        adv       = 1'b0;
        iss_valid = 1'b0;
        res_valid = 1'b0;
        #1;
        chk("flush_haz", 32'(hazard), 0);
        chk("flush_fwd", fwd_data, {16'hBEEF, 16'hCAFE});

        // Fill all stages with results, then drain in order
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{num: AW'(i), data: 16'hA000 + DW'(i)});
            if (i > 0) result(3'd1, 16'hA000 + DW'(i - 1));
            issue(AW'(i));
            res_valid = 1'b0;
        end
        result(3'd1, 16'hA005);
        tick();
        res_valid = 1'b0;
        rd_num = {3'd0, 3'd5};
        #1;
        chk("full_r5", fwd_data[15:0], 16'hA005);
        chk("full_r0", fwd_data[31:16], 16'hA000);
        adv = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        adv = 1'b0;
        #1;
        chk("drain_cnt", 32'(ret_cnt), 6);
        chk("drain_err", 32'(ret_err), 0);

        // Result delivered to the oldest stage in its retire cycle
        sb.push_back('{num: 3'd1, data: 16'h5A5A});
        issue(3'd1);
        adv = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        result(3'd6, 16'h5A5A);
        tick();
        adv       = 1'b0;
        res_valid = 1'b0;
        #1;
        chk("byp_ret_cnt", 32'(ret_cnt), 7);
        chk("byp_ret_err", 32'(ret_err), 0);

        // Unresolved retire raises sticky error
        sb.push_back('{num: 3'd6, data: 16'h0000});
        issue(3'd6);
        adv = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #1 chk("pre_err", 32'(ret_err), 0);
        tick();
        adv = 1'b0;
        #1 chk("err_set", 32'(ret_err), 1);
        tick();
        chk("err_sticky", 32'(ret_err), 1);
        chk("unres_cnt", 32'(ret_cnt), 8);

        // Reset mid-stream, off the clock edge
        issue(3'd4);
        adv = 1'b1;
        result(3'd1, 16'h4444);
        tick();
        res_valid = 1'b0;
        tick();
        adv    = 1'b0;
        rd_num = {3'd4, 3'd4};
        #1 chk("r4_pre", fwd_data[15:0], 16'h4444);
        rst_n = 1'b0;
        #1;
        chk("arst_fwd", fwd_data, {16'hBEEF, 16'hCAFE});
        chk("arst_err", 32'(ret_err), 0);
        chk("arst_haz", 32'(hazard), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        adv = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        adv = 1'b0;
        #1;
        chk("post_rst_cnt", 32'(ret_cnt), 8);
        chk("post_rst_fwd", fwd_data[15:0], 16'hCAFE);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
